// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master, single-outstanding-transfer arbiter in front of a shared slave
// bus. Each master raises req (with we/addr/wdata) and holds it until its
// done pulse. The arbiter grants one master at a time, round-robin when both
// request, decodes addr[31:28] into a one-hot slave select and runs the
// transfer on the shared bus. A transfer ends on mem_ready, on a timeout, or
// immediately when the address is unmapped. The result is returned as a
// one-cycle done pulse with err and m_rdata.
//
// Handshake: the shared bus is valid/ready. While mem_valid=1 the command
// (mem_we/mem_addr/mem_wdata/mem_sel) is stable and the transfer completes
// on the first rising edge with mem_ready=1 (mem_rdata sampled on that edge).
// mem_ready is ignored whenever mem_valid=0. On the master side req is held
// until done; done/err/m_rdata form a single-cycle response.
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   m0_* / m1_*             : master request (req, we, addr, wdata) and
//                             response (done, err)
//   m_rdata                 : read data, valid with either done, else 0
//   mem_valid/we/addr/wdata : shared bus command
//   mem_sel                 : one-hot select rom,ram,gpio,spi,uart,timer
//   mem_ready, mem_rdata    : slave completion and read data
//   dbg_state               : FSM state (0 IDLE, 1 BUSY, 2 RESP)
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m_rdata,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [5:0]  mem_sel,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value of the last BUSY cycle allowed before a timeout.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        last_m1;     // master granted most recently (1 = m1)
  logic        gnt_m1;      // master owning the current transfer
  logic        mapped_q;    // current transfer targets a real slave
  logic [7:0]  busy_cnt;    // BUSY cycles elapsed, 0 on entry

  logic        req_any;
  logic        pick_m1;
  logic        pick_we;
  logic [31:0] pick_addr;
  logic [31:0] pick_wdata;
  logic [5:0]  pick_sel;
  logic        pick_mapped;

  logic        busy_exit;
  logic        busy_err;
  logic [31:0] busy_rdata;

  function automatic logic [5:0] decode_sel(input logic [3:0] region);
    logic [5:0] sel;
    case (region)
      4'h0:    sel = 6'b000001;  // rom
      4'h1:    sel = 6'b000010;  // ram
      4'h2:    sel = 6'b000100;  // gpio
      4'h3:    sel = 6'b001000;  // spi
      4'h4:    sel = 6'b010000;  // uart
      4'h5:    sel = 6'b100000;  // timer
      default: sel = 6'b000000;  // unmapped
    endcase
    return sel;
  endfunction

  // Grant selection: with both requesting, the one not served last wins;
  // otherwise whichever is requesting.
  always_comb begin
    req_any     = m0_req | m1_req;
    pick_m1     = (m0_req & m1_req) ? ~last_m1 : m1_req;
    pick_we     = pick_m1 ? m1_we    : m0_we;
    pick_addr   = pick_m1 ? m1_addr  : m0_addr;
    pick_wdata  = pick_m1 ? m1_wdata : m0_wdata;
    pick_sel    = decode_sel(pick_addr[31:28]);
    pick_mapped = |pick_sel;
  end

  // Exit condition of the BUSY state. Unmapped transfers leave after one
  // cycle without looking at mem_ready; ready wins over a same-cycle timeout.
  always_comb begin
    busy_exit  = 1'b0;
    busy_err   = 1'b0;
    busy_rdata = '0;
    if (!mapped_q) begin
      busy_exit = 1'b1;
      busy_err  = 1'b1;
    end else if (mem_ready) begin
      busy_exit  = 1'b1;
      busy_rdata = mem_we ? 32'h0 : mem_rdata;
    end else if (busy_cnt == CNT_LAST) begin
      busy_exit = 1'b1;
      busy_err  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_m1   <= 1'b1;
      gnt_m1    <= 1'b0;
      mapped_q  <= 1'b0;
      busy_cnt  <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sel   <= '0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            state     <= BUSY;
            gnt_m1    <= pick_m1;
            mapped_q  <= pick_mapped;
            busy_cnt  <= '0;
            // Unmapped transfers never drive the shared bus.
            mem_valid <= pick_mapped;
            mem_sel   <= pick_sel;
            mem_we    <= pick_mapped & pick_we;
            mem_addr  <= pick_mapped ? pick_addr  : 32'h0;
            mem_wdata <= pick_mapped ? pick_wdata : 32'h0;
          end
        end
        BUSY: begin
          if (busy_exit) begin
            state     <= RESP;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_sel   <= '0;
            m0_done   <= ~gnt_m1;
            m1_done   <= gnt_m1;
            m0_err    <= ~gnt_m1 & busy_err;
            m1_err    <= gnt_m1 & busy_err;
            m_rdata   <= busy_rdata;
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
          end
        end
        RESP: begin
          state   <= IDLE;
          last_m1 <= gnt_m1;
          m0_done <= 1'b0;
          m1_done <= 1'b0;
          m0_err  <= 1'b0;
          m1_err  <= 1'b0;
          m_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter. A timeline model predicts, from the
// request/ready history, in which cycle each transfer is on the bus and in
// which cycle its done pulse appears; a compare process checks every cycle
// against it. Directed tests add hand-computed latencies and values.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  // ---------------------------------------------------------------- signals
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic [31:0] m_rdata;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [5:0]  mem_sel;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [0:0] exp_q[$];

  // slave behaviour
  int  ready_after = NEVER;
  bit  stray_ready = 1'b0;
  int  slave_cnt   = 0;

  bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_done   (m0_done),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_done   (m1_done),
    .m1_err    (m1_err),
    .m_rdata   (m_rdata),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_sel   (mem_sel),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------- clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  // ------------------------------------------------------------- checking
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------- timeline model
  // Cycle c is the clock period ending at posedge number c. A transfer
  // sampled in cycle g is on the bus from g+1 until its done cycle; done
  // follows the cycle with ready, or cycle g+TIMEOUT without ready, or is
  // at g+2 for an unmapped address. The next grant can be sampled no
  // earlier than the cycle after done.
  int          cyc = 0;
  int          now_c;
  bit          x_act = 1'b0;
  int          x_g, x_done_at, x_free = 0;
  int          x_mst, x_last = 1;
  logic        x_we;
  logic [31:0] x_addr, x_wdata, x_rd;
  logic [5:0]  x_sel;
  bit          x_mapped, x_err;

  logic        e_valid = 1'b0, e_unm = 1'b0;
  logic        e_done0 = 1'b0, e_done1 = 1'b0;
  logic        e_err0 = 1'b0, e_err1 = 1'b0;
  logic        e_own0 = 1'b0, e_own1 = 1'b0;
  logic [31:0] e_rdata = '0;

  initial forever begin
    @(posedge clk);
    now_c = cyc;
    cyc   = cyc + 1;
    if (rst) begin
      x_act  = 1'b0;
      x_last = 1;
      x_free = now_c + 1;
    end else begin
      if (x_act && now_c == x_done_at) begin
        x_act  = 1'b0;
        x_last = x_mst;
        x_free = now_c + 1;
      end
      if (x_act && x_done_at < 0 && now_c >= x_g + 1) begin
        if (mem_ready) begin
          x_done_at = now_c + 1;
          x_err     = 1'b0;
          x_rd      = x_we ? 32'h0 : mem_rdata;
        end else if (now_c == x_g + TIMEOUT) begin
          x_done_at = now_c + 1;
          x_err     = 1'b1;
          x_rd      = 32'h0;
        end
      end
      if (!x_act && now_c >= x_free && (m0_req || m1_req)) begin
        if (m0_req && m1_req) x_mst = 1 - x_last;
        else                  x_mst = m0_req ? 0 : 1;
        x_act     = 1'b1;
        x_g       = now_c;
        x_done_at = -1;
        x_we      = (x_mst == 0) ? m0_we    : m1_we;
        x_addr    = (x_mst == 0) ? m0_addr  : m1_addr;
        x_wdata   = (x_mst == 0) ? m0_wdata : m1_wdata;
        x_mapped  = (x_addr[31:28] <= 4'h5);
        x_sel     = x_mapped ? 6'(1 << x_addr[31:28]) : 6'b0;
        if (!x_mapped) begin
          x_done_at = now_c + 2;
          x_err     = 1'b1;
          x_rd      = 32'h0;
        end
      end
    end
    // expectations for the cycle now starting
    e_valid = x_act && x_mapped && (now_c + 1 > x_g) &&
              (x_done_at < 0 || now_c + 1 < x_done_at);
    e_unm   = x_act && !x_mapped && (now_c + 1 == x_g + 1);
    e_done0 = x_act && (now_c + 1 == x_done_at) && x_mst == 0;
    e_done1 = x_act && (now_c + 1 == x_done_at) && x_mst == 1;
    e_err0  = e_done0 ? x_err : 1'b0;
    e_err1  = e_done1 ? x_err : 1'b0;
    e_own0  = x_act && x_mst == 0 && !e_done0;
    e_own1  = x_act && x_mst == 1 && !e_done1;
    e_rdata = (e_done0 || e_done1) ? x_rd : 32'h0;
  end

  // compare process: every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    check("cyc_mem_valid", 32'(mem_valid), 32'(e_valid));
    if (e_valid) begin
      check("cyc_mem_sel",   32'(mem_sel), 32'(x_sel));
      check("cyc_mem_we",    32'(mem_we),  32'(x_we));
      check("cyc_mem_addr",  mem_addr,     x_addr);
      check("cyc_mem_wdata", mem_wdata,    x_wdata);
    end
    if (e_unm) check("cyc_unmapped_sel", 32'(mem_sel), 32'h0);
    check("cyc_m0_done", 32'(m0_done), 32'(e_done0));
    check("cyc_m1_done", 32'(m1_done), 32'(e_done1));
    check("cyc_m_rdata", m_rdata, e_rdata);
    if (!e_own0) check("cyc_m0_err", 32'(m0_err), 32'(e_err0));
    if (!e_own1) check("cyc_m1_err", 32'(m1_err), 32'(e_err1));
  end

  // slave: ready on the ready_after-th cycle of a bus transfer
  initial forever begin
    @(negedge clk);
    if (mem_valid) begin
      slave_cnt = slave_cnt + 1;
      mem_ready = (slave_cnt == ready_after);
    end else begin
      slave_cnt = 0;
      mem_ready = stray_ready;
    end
  end

  // ------------------------------------------------------------ drivers
  task automatic set_master(input int mst, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
    if (mst == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_valid"}, 32'(mem_valid), 32'h0);
    check({tag, "_mem_we"},    32'(mem_we),    32'h0);
    check({tag, "_mem_addr"},  mem_addr,       32'h0);
    check({tag, "_mem_wdata"}, mem_wdata,      32'h0);
    check({tag, "_mem_sel"},   32'(mem_sel),   32'h0);
    check({tag, "_dones"},     32'({m0_done, m1_done}), 32'h0);
    check({tag, "_errs"},      32'({m0_err, m1_err}),   32'h0);
    check({tag, "_m_rdata"},   m_rdata,        32'h0);
    check({tag, "_state"},     32'(dbg_state), 32'h0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  // Runs one transfer starting at a negedge in an IDLE cycle. lat counts
  // negedges from the request to the done pulse.
  task automatic run_xfer(input int mst, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int rdy, input logic [31:0] srd,
                          input int drop_after, output int lat, output logic err,
                          output logic [31:0] rd, output int vcyc,
                          output logic [5:0] sel_seen, output int n_done);
    bit got = 1'b0;
    ready_after = rdy;
    mem_rdata   = srd;
    lat = 0; vcyc = 0; n_done = 0; err = 1'b0; rd = '0; sel_seen = '0;
    set_master(mst, 1'b1, we, addr, wdata);
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_valid) begin
        vcyc++;
        sel_seen = mem_sel;
      end
      if (lat == drop_after) set_master(mst, 1'b0, we, addr, wdata);
      if ((mst == 0) ? m0_done : m1_done) begin
        got = 1'b1;
        n_done++;
        err = (mst == 0) ? m0_err : m1_err;
        rd  = m_rdata;
      end
    end
    set_master(mst, 1'b0, 1'b0, 32'h0, 32'h0);
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL xfer_wait: no done from m%0d within 40 cycles", mst);
    end
    @(negedge clk);
    if ((mst == 0) ? m0_done : m1_done) n_done++;
  endtask

  // ---------------------------------------------------------------- tests
  typedef struct {
    logic [31:0] addr;
    logic [5:0]  sel;
  } dec_vec_t;

  initial begin
    int          lat, vcyc, nd, first;
    int          prev_done, n_seen;
    logic        err;
    logic [31:0] rd;
    logic [5:0]  sel;
    dec_vec_t    dec_tab[4];

    dec_tab[0] = '{32'h0000_0010, 6'b000001};
    dec_tab[1] = '{32'h3000_0020, 6'b001000};
    dec_tab[2] = '{32'h4FFF_FFFC, 6'b010000};
    dec_tab[3] = '{32'h5000_0100, 6'b100000};

    // reset state
    @(negedge clk);
    reset_pulse();

    // single read from ram, ready on first bus cycle
    run_xfer(0, 1'b0, 32'h1000_0040, 32'h0, 1, 32'hCAFE_0001, 0, lat, err, rd, vcyc, sel, nd);
    check("read_latency", 32'(lat), 32'd2);
    check("read_sel",     32'(sel), 32'b000010);
    check("read_rdata",   rd,       32'hCAFE_0001);
    check("read_err",     32'(err), 32'h0);
    check("read_ndone",   32'(nd),  32'd1);

    // write from m1: rdata returns 0 even with slave data present
    run_xfer(1, 1'b1, 32'h1000_0100, 32'h1234_5678, 2, 32'hDEAD_BEEF, 0, lat, err, rd, vcyc, sel, nd);
    check("write_latency", 32'(lat), 32'd3);
    check("write_rdata",   rd,       32'h0);
    check("write_err",     32'(err), 32'h0);

    // timeout on timer write
    run_xfer(1, 1'b1, 32'h5000_0000, 32'hA5A5_0000, NEVER, 32'h1111_1111, 0, lat, err, rd, vcyc, sel, nd);
    check("timeout_latency", 32'(lat),  32'd17);
    check("timeout_vcycles", 32'(vcyc), 32'd16);
    check("timeout_err",     32'(err),  32'h1);
    check("timeout_rdata",   rd,        32'h0);
    check("timeout_sel",     32'(sel),  32'b100000);

    // ready in the last cycle before the timeout still succeeds
    run_xfer(0, 1'b0, 32'h2000_0004, 32'h0, 16, 32'h0000_00A5, 0, lat, err, rd, vcyc, sel, nd);
    check("edge_latency", 32'(lat),  32'd17);
    check("edge_vcycles", 32'(vcyc), 32'd16);
    check("edge_err",     32'(err),  32'h0);
    check("edge_rdata",   rd,        32'h0000_00A5);

    // unmapped address, with a stray ready that must be ignored
    stray_ready = 1'b1;
    run_xfer(0, 1'b0, 32'hF000_0000, 32'h0, 1, 32'h7777_7777, 0, lat, err, rd, vcyc, sel, nd);
    stray_ready = 1'b0;
    check("unmapped_latency", 32'(lat),  32'd2);
    check("unmapped_vcycles", 32'(vcyc), 32'd0);
    check("unmapped_err",     32'(err),  32'h1);
    check("unmapped_rdata",   rd,        32'h0);

    // first unmapped region
    run_xfer(1, 1'b1, 32'h6000_0000, 32'h5555_AAAA, 1, 32'h0, 0, lat, err, rd, vcyc, sel, nd);
    check("region6_latency", 32'(lat), 32'd2);
    check("region6_err",     32'(err), 32'h1);

    // decode table
    foreach (dec_tab[i]) begin
      run_xfer(i % 2, 1'b0, dec_tab[i].addr, 32'h0, 1, 32'h0000_1000 + 32'(i), 0, lat, err, rd, vcyc, sel, nd);
      check("decode_sel",   32'(sel), 32'(dec_tab[i].sel));
      check("decode_rdata", rd,       32'h0000_1000 + 32'(i));
    end

    // req dropped after grant, slave ready on third bus cycle
    run_xfer(0, 1'b0, 32'h3000_0008, 32'h0, 3, 32'h0BAD_F00D, 1, lat, err, rd, vcyc, sel, nd);
    check("drop_latency", 32'(lat), 32'd4);
    check("drop_ndone",   32'(nd),  32'd1);
    check("drop_rdata",   rd,       32'h0BAD_F00D);

    // reset on the third bus cycle; m0 was granted last, yet must win after
    ready_after = NEVER;
    set_master(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_mid_busy", 32'(mem_valid), 32'h1);
    rst = 1'b1;
    set_master(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check_all_zero("rst_mid");
    rst = 1'b0;
    ready_after = 1;
    set_master(0, 1'b1, 1'b0, 32'h1000_0010, 32'h0);
    set_master(1, 1'b1, 1'b0, 32'h1000_0014, 32'h0);
    first = -1;
    for (int k = 0; k < 10 && first < 0; k++) begin
      @(negedge clk);
      if (m0_done || m1_done) first = m1_done ? 1 : 0;
    end
    check("rst_first_grant", 32'(first), 32'd0);
    set_master(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_master(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    // contention from reset: alternating grants, done every 3 cycles
    reset_pulse();
    ready_after = 1;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    set_master(0, 1'b1, 1'b0, 32'h1000_0010, 32'h0);
    set_master(1, 1'b1, 1'b1, 32'h2000_0020, 32'hFEED_0002);
    prev_done = -1;
    n_seen = 0;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      if (m0_done || m1_done) begin
        check("contention_order", 32'(m1_done), 32'(exp_q.pop_front()));
        if (prev_done >= 0) check("contention_spacing", 32'(k - prev_done), 32'd3);
        prev_done = k;
        n_seen++;
      end
    end
    set_master(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_master(1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("contention_count", 32'(n_seen), 32'd4);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
